// File: rtl/forward_hazard_unit.sv
// rtl/forward_hazard_unit.sv - EX operand forwarding select and load-use stall generation
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   id_valid                  real instruction present in ID
//   id_rs, id_rt              ID source registers
//   id_reg_w, id_mem_r        ID writes a register / ID is a load
//   id_wb_addr                ID destination register
//   flush                     kill the ID instruction
//   a_forward_ctr             EX operand A source: 0 = register file, k = post-EX stage k
//   b_forward_ctr             EX operand B source, same encoding
//   stall                     hold PC/IF/ID and insert a bubble into EX
//   stall_cnt                 saturating count of stall cycles
module forward_hazard_unit #(
  parameter int register_addr = 5,
  parameter int fwd_depth     = 2,
  parameter int load_latency  = 1,
  parameter int cnt_width     = 16,
  localparam int sel_w        = $clog2(fwd_depth + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [register_addr-1:0] id_rs,
  input  logic [register_addr-1:0] id_rt,
  input  logic                     id_reg_w,
  input  logic                     id_mem_r,
  input  logic [register_addr-1:0] id_wb_addr,
  input  logic                     flush,
  output logic [sel_w-1:0]         a_forward_ctr,
  output logic [sel_w-1:0]         b_forward_ctr,
  output logic                     stall,
  output logic [cnt_width-1:0]     stall_cnt
);

  // Writer records: index 0 is the EX occupant, index k is k stages past EX.
  logic                     valid_q [0:fwd_depth];
  logic                     valid_d [0:fwd_depth];
  logic [register_addr-1:0] addr_q  [0:fwd_depth];
  logic [register_addr-1:0] addr_d  [0:fwd_depth];
  logic                     load_q  [0:fwd_depth];
  logic                     load_d  [0:fwd_depth];

  // Source operands of the EX occupant.
  logic                     ex_valid_q, ex_valid_d;
  logic [register_addr-1:0] ex_rs_q, ex_rs_d;
  logic [register_addr-1:0] ex_rt_q, ex_rt_d;

  logic [cnt_width-1:0]     stall_cnt_q, stall_cnt_d;

  logic                     load_hit;
  logic                     bubble;

  // Load-use detection: a load that has not yet reached a forwardable stage
  // and writes a register the ID instruction reads. Register 0 never matches.
  always_comb begin
    load_hit = 1'b0;
    for (int j = 0; j < load_latency; j++) begin
      if (valid_q[j] && load_q[j] && (addr_q[j] != '0) &&
          ((addr_q[j] == id_rs) || (addr_q[j] == id_rt))) begin
        load_hit = 1'b1;
      end
    end
  end

  // Flush and reset both suppress the stall.
  assign stall  = !rst && id_valid && !flush && load_hit;
  assign bubble = stall || flush;

  // Forward selects: scan oldest to youngest so the youngest match wins.
  always_comb begin
    a_forward_ctr = '0;
    b_forward_ctr = '0;
    if (ex_valid_q) begin
      for (int k = fwd_depth; k >= 1; k--) begin
        if (valid_q[k] && (addr_q[k] != '0) && (addr_q[k] == ex_rs_q)) begin
          a_forward_ctr = sel_w'(k);
        end
        if (valid_q[k] && (addr_q[k] != '0) && (addr_q[k] == ex_rt_q)) begin
          b_forward_ctr = sel_w'(k);
        end
      end
    end
  end

  always_comb begin
    valid_d[0] = id_valid && id_reg_w && !bubble;
    addr_d[0]  = id_wb_addr;
    load_d[0]  = id_mem_r;
    ex_valid_d = id_valid && !bubble;
    ex_rs_d    = id_rs;
    ex_rt_d    = id_rt;
    // Post-EX stages advance every cycle; a stall only freezes the front end.
    for (int k = 1; k <= fwd_depth; k++) begin
      valid_d[k] = valid_q[k-1];
      addr_d[k]  = addr_q[k-1];
      load_d[k]  = load_q[k-1];
    end
    stall_cnt_d = stall_cnt_q;
    if (stall && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + cnt_width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= fwd_depth; k++) begin
        valid_q[k] <= 1'b0;
        addr_q[k]  <= '0;
        load_q[k]  <= 1'b0;
      end
      ex_valid_q  <= 1'b0;
      ex_rs_q     <= '0;
      ex_rt_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int k = 0; k <= fwd_depth; k++) begin
        valid_q[k] <= valid_d[k];
        addr_q[k]  <= addr_d[k];
        load_q[k]  <= load_d[k];
      end
      ex_valid_q  <= ex_valid_d;
      ex_rs_q     <= ex_rs_d;
      ex_rt_q     <= ex_rt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/forward_hazard_unit.md
FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

Interface
REQ-001 The block SHALL have parameter register_addr, default 5, meaning the register-address width.
REQ-002 The block SHALL have parameter fwd_depth, default 2, meaning the number of post-EX stages tracked for forwarding (legal 1..4).
REQ-003 The block SHALL have parameter load_latency, default 1, meaning the stages after EX before load data is forwardable (legal 0..fwd_depth-1).
REQ-004 The block SHALL have parameter cnt_width, default 16, meaning the stall-counter width.
REQ-005 The block SHALL define localparam sel_w = clog2(fwd_depth+1).
REQ-006 Port clk  input  1  is the single clock; every register updates on its rising edge.
REQ-007 Port rst  input  1  is the reset: synchronous, active-high.
REQ-008 Port id_valid  input  1  means a real instruction is in ID.
REQ-009 Ports id_rs, id_rt  input  register_addr  are the ID source registers.
REQ-010 Ports id_reg_w, id_mem_r  input  1  are the ID register-write flag and load flag.
REQ-011 Port id_wb_addr  input  register_addr  is the ID destination register.
REQ-012 Port flush  input  1  kills the ID instruction.
REQ-013 Ports a_forward_ctr, b_forward_ctr  output  sel_w  select the EX operand source: 0 = register file; k = stage k (1 = youngest post-EX).
REQ-014 Port stall  output  1  holds PC/IF/ID and inserts a bubble into EX.
REQ-015 Port stall_cnt  output  cnt_width  is a saturating count of stall cycles.

Function
REQ-016 The block SHALL keep records S0..S[fwd_depth] of {valid, wb_addr, is_load}: S0 = EX occupant, Sk = k stages after EX. It SHALL also keep ex_valid, ex_rs and ex_rt for the EX occupant.
REQ-017 Each cycle with stall=0 and flush=0, S0 SHALL load {id_valid&&id_reg_w, id_wb_addr, id_mem_r} and ex_* SHALL load {id_valid, id_rs, id_rt}.
REQ-018 With stall=1 or flush=1, S0.valid and ex_valid SHALL load 0 (bubble).
REQ-019 S[k] SHALL load S[k-1] every cycle for k>=1, unconditionally; S[fwd_depth] is discarded on the next shift.
REQ-020 A record SHALL match source r only when its valid=1, r != 0, and wb_addr == r.
REQ-021 a_forward_ctr SHALL equal the smallest k in 1..fwd_depth whose Sk matches ex_rs (youngest wins); it SHALL be 0 when there is no match or ex_valid=0. b_forward_ctr SHALL follow the same rule with ex_rt.
REQ-022 Outputs a_forward_ctr and b_forward_ctr SHALL be combinational from registers only.
REQ-023 stall SHALL be 1 iff id_valid=1, flush=0, and some Sj with j in 0..load_latency-1 has is_load=1 and matches id_rs or id_rt. stall SHALL be 0 when load_latency=0.
REQ-024 A load record at stage k<=load_latency SHALL never be selected for forwarding; the REQ-023 stall guarantees this.
REQ-025 A matching non-load record SHALL never cause a stall.
REQ-026 flush SHALL override stall in the same cycle (stall=0). The bubble is inserted and stall_cnt does not increment.
REQ-027 stall_cnt SHALL increment by 1 each cycle stall=1 and hold at 2^cnt_width-1 (no wrap).
REQ-028 When id_wb_addr equals id_rs of the same instruction, the block SHALL compare only against older records, never self-match.

Reset
REQ-029 While rst=1 at a clock edge, every S valid, ex_valid and stall_cnt SHALL load 0, and all wb_addr/ex_rs/ex_rt SHALL load 0.
REQ-030 In the cycle after reset, a_forward_ctr=0, b_forward_ctr=0 and stall=0. stall SHALL be 0 during rst=1 regardless of inputs.
REQ-031 Reset SHALL take priority over stall and flush mid-operation; in-flight records SHALL be discarded.

Verification (defaults: fwd_depth=2, load_latency=1)
REQ-032 ALU writes r3, next instruction reads rs=r3 -> when the consumer is in EX, a_forward_ctr=1, b_forward_ctr=0, stall never asserted.
REQ-033 Back-to-back writes to r5, then a reader with rt=r5 -> b_forward_ctr=1 (youngest), not 2.
REQ-034 Load r7, then next instruction reads rs=r7 -> stall=1 for exactly 1 cycle, stall_cnt 0->1, then the consumer enters EX with a_forward_ctr=2.
REQ-035 Writes to r0 and matching reads of r0 -> forward ctrs stay 0 and stall=0.
REQ-036 Load-use hazard with flush=1 in the same cycle -> stall=0, stall_cnt unchanged, EX shows bubble (ctrs 0 next cycle).
REQ-037 cnt_width=2 with 5 forced stall cycles -> stall_cnt 1,2,3,3,3; then rst=1 -> stall_cnt=0 and ctrs 0 the next cycle.
